// File: rtl/gauss_window_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gauss_pkg
// Purpose  : Shared definitions for the 3x3 Gaussian window sequencer:
//            controller state encoding, border flag bit positions and a
//            constant-evaluable ceil(log2) helper for sizing counters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gauss_pkg;

    // Controller states. Explicit 3-bit encoding keeps the register width
    // fixed regardless of tool enum sizing.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Bit positions inside the 4-bit border vector {top, bottom, left, right}.
    localparam int TOP      = 3;
    localparam int BOTTOM   = 2;
    localparam int LEFT     = 1;
    localparam int RIGHT    = 0;
    localparam int BORDER_W = 4;

    // ceil(log2(value)), never less than 1 so that a counter for a range
    // of one or two values still gets a legal one-bit vector.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gauss_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : gauss_window_if
// Purpose  : Bundles the pixel-source handshake and the window-array control
//            outputs of the Gaussian window sequencer.
// Ports    : start, in_valid            - driven by the source (master)
//            in_ready, shift_ce         - handshake / register enable
//            out_valid, out_x, out_y    - centre pixel of the current window
//            border                     - {top, bottom, left, right}
//            busy, done                 - frame status
//            master modport: pixel source / frame scheduler side
//            slave  modport: the sequencer itself
// Revision : 1.0 - initial release
// ============================================================================
interface gauss_window_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          shift_ce;
    logic          out_valid;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic [3:0]    border;
    logic          busy;
    logic          done;

    modport master (
        output start,
        output in_valid,
        input  in_ready,
        input  shift_ce,
        input  out_valid,
        input  out_x,
        input  out_y,
        input  border,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  in_valid,
        output in_ready,
        output shift_ce,
        output out_valid,
        output out_x,
        output out_y,
        output border,
        output busy,
        output done
    );

endinterface
`default_nettype wire

// File: rtl/gauss_window_ctrl_pos.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pos_counter
// Purpose  : Raster position counter for a W x H frame. Advances one pixel
//            per enabled cycle, x wrapping into y, y wrapping to 0 so the
//            counter naturally re-arms for the next frame.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            en   - advance by one pixel
//            x, y - current column / row
//            last - current position is (W-1, H-1)
// Revision : 1.0 - initial release
// ============================================================================
module pixel_pos_counter
    import gauss_pkg::*;
#(
    parameter int W = 640,
    parameter int H = 480
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  en,
    output logic [clog2(W)-1:0]        x,
    output logic [clog2(H)-1:0]        y,
    output logic                       last
);

    localparam int             XW    = clog2(W);
    localparam int             YW    = clog2(H);
    localparam logic [XW-1:0]  X_MAX = XW'(W - 1);
    localparam logic [YW-1:0]  Y_MAX = YW'(H - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    assign last = (x == X_MAX) && (y == Y_MAX);

endmodule
`default_nettype wire

// File: rtl/gauss_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gauss_window_ctrl
// Purpose  : Sequencer for the 3x3 Gaussian window datapath. Generates the
//            shared clock enable for window registers and line-buffer taps,
//            tracks input and window-centre raster positions, flags border
//            centres and drains the pipeline after the last input pixel.
// Ports    : clk  - clock, all logic on the rising edge
//            rst  - synchronous active-high reset (abandons a frame)
//            bus  - gauss_window_if.slave: start / in_valid in;
//                   in_ready, shift_ce, out_valid, out_x, out_y, border,
//                   busy, done out
// Revision : 1.0 - initial release
// ============================================================================
module gauss_window_ctrl
    import gauss_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  wire logic      clk,
    input  wire logic      rst,
    gauss_window_if.slave  bus
);

    localparam int XW = clog2(IMG_W);
    localparam int YW = clog2(IMG_H);
    // Phase counter covers both the fill count and the flush count; both
    // terminate after IMG_W+1 events, i.e. when the counter reads IMG_W.
    localparam int            CW         = clog2(IMG_W + 2);
    localparam logic [CW-1:0] PHASE_LAST = CW'(IMG_W);

    // ------------------------------------------------------------------
    // State and control
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_phase;

    logic            w_in_ready;
    logic            w_accept;     // pixel taken from the source this cycle
    logic            w_shift;      // window/line-buffer enable
    logic            w_out_shift;  // shift that produces a complete window
    logic            w_phase_clr;
    logic            w_phase_inc;

    // Position counters
    logic [XW-1:0]   w_in_x;
    logic [YW-1:0]   w_in_y;
    logic            w_in_last;
    logic [XW-1:0]   w_out_x;
    logic [YW-1:0]   w_out_y;
    logic            w_out_last;

    // Registered window-centre outputs
    logic            r_out_valid;
    logic [XW-1:0]   r_out_x;
    logic [YW-1:0]   r_out_y;
    logic [3:0]      r_border;
    logic [3:0]      w_border_next;

    // Counter outputs that the control path does not consume; they remain
    // available for debug probing of the frame position.
    logic            w_unused;
    assign w_unused = ^{w_in_x, w_in_y, w_out_last};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        w_out_shift  = 1'b0;
        w_phase_clr  = 1'b0;
        w_phase_inc  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = FILL;
                end
            end

            // Priming the line buffers: pixels shift in but the window
            // does not yet hold a valid centre.
            FILL: begin
                w_in_ready = 1'b1;
                w_accept   = bus.in_valid;
                w_shift    = w_accept;
                if (w_accept) begin
                    if (r_phase == PHASE_LAST) begin
                        w_phase_clr  = 1'b1;
                        w_state_next = RUN;
                    end else begin
                        w_phase_inc  = 1'b1;
                    end
                end
            end

            // Steady state: each accepted pixel completes one window.
            RUN: begin
                w_in_ready  = 1'b1;
                w_accept    = bus.in_valid;
                w_shift     = w_accept;
                w_out_shift = w_accept;
                if (w_accept && w_in_last) begin
                    w_state_next = FLUSH;
                end
            end

            // No more source pixels: keep shifting to push the trailing
            // IMG_W+1 centres through the window.
            FLUSH: begin
                w_shift     = 1'b1;
                w_out_shift = 1'b1;
                if (r_phase == PHASE_LAST) begin
                    w_phase_clr  = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_phase_inc  = 1'b1;
                end
            end

            DONE: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (w_phase_clr) begin
            r_phase <= '0;
        end else if (w_phase_inc) begin
            r_phase <= r_phase + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Position counters: input pixel and window centre. The centre counter
    // only moves on window-producing shifts, so it trails the input by
    // exactly IMG_W+1 pixels.
    // ------------------------------------------------------------------
    pixel_pos_counter #(
        .W (IMG_W),
        .H (IMG_H)
    ) u_in_pos (
        .clk  (clk),
        .rst  (rst),
        .en   (w_accept),
        .x    (w_in_x),
        .y    (w_in_y),
        .last (w_in_last)
    );

    pixel_pos_counter #(
        .W (IMG_W),
        .H (IMG_H)
    ) u_out_pos (
        .clk  (clk),
        .rst  (rst),
        .en   (w_out_shift),
        .x    (w_out_x),
        .y    (w_out_y),
        .last (w_out_last)
    );

    // ------------------------------------------------------------------
    // Window-centre outputs. Captured on the same edge that shifts the
    // window registers, so they line up with the updated register q's.
    // ------------------------------------------------------------------
    always_comb begin
        w_border_next         = '0;
        w_border_next[TOP]    = (w_out_y == '0);
        w_border_next[BOTTOM] = (w_out_y == YW'(IMG_H - 1));
        w_border_next[LEFT]   = (w_out_x == '0);
        w_border_next[RIGHT]  = (w_out_x == XW'(IMG_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_border    <= '0;
        end else begin
            r_out_valid <= w_out_shift;
            r_border    <= w_out_shift ? w_border_next : '0;
            if (w_out_shift) begin
                r_out_x <= w_out_x;
                r_out_y <= w_out_y;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.shift_ce  = w_shift;
    assign bus.out_valid = r_out_valid;
    assign bus.out_x     = r_out_x;
    assign bus.out_y     = r_out_y;
    assign bus.border    = r_border;
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_gauss_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gauss_window_ctrl
// Purpose  : Scoreboard bench for gauss_window_ctrl. Two instances: a 4x3
//            frame and a 2x2 corner-case frame. Stimulus pushes the expected
//            window sequence; per-instance monitors pop and compare whenever
//            out_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gauss_window_ctrl;
    import gauss_pkg::*;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] b;
        logic       last;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      start_s;
    logic [1:0]      vld_s;
    logic [1:0]      rdy_s;
    logic [1:0]      ce_s;
    logic [1:0]      ov_s;
    logic [1:0]      busy_s;
    logic [1:0]      done_s;
    logic [1:0][7:0] ox_s;
    logic [1:0][7:0] oy_s;
    logic [1:0][3:0] bd_s;

    int   total = 0;
    int   bad   = 0;
    win_t exp_q [2][$];
    int   acc_cnt   [2];
    int   win_cnt   [2];
    int   flush_cyc [2];
    int   done_cnt  [2];

    // Hand-derived border flags {top,bottom,left,right} in raster order.
    logic [3:0] b43 [12] = '{4'b1010, 4'b1000, 4'b1000, 4'b1001,
                             4'b0010, 4'b0000, 4'b0000, 4'b0001,
                             4'b0110, 4'b0100, 4'b0100, 4'b0101};
    logic [3:0] b22 [4]  = '{4'b1010, 4'b1001, 4'b0110, 4'b0101};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int W = (g == 0) ? 4 : 2;
        localparam int H = (g == 0) ? 3 : 2;
        localparam int N = W * H;

        gauss_window_if #(.XW(clog2(W)), .YW(clog2(H))) bus ();

        assign bus.start    = start_s[g];
        assign bus.in_valid = vld_s[g];
        assign rdy_s[g]     = bus.in_ready;
        assign ce_s[g]      = bus.shift_ce;
        assign ov_s[g]      = bus.out_valid;
        assign busy_s[g]    = bus.busy;
        assign done_s[g]    = bus.done;
        assign ox_s[g]      = 8'(bus.out_x);
        assign oy_s[g]      = 8'(bus.out_y);
        assign bd_s[g]      = bus.border;

        gauss_window_ctrl #(
            .IMG_W (W),
            .IMG_H (H)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        win_t e;
        int   exp_acc;

        always @(negedge clk) begin
            if (rst) begin
                acc_cnt[g]   = 0;
                win_cnt[g]   = 0;
                flush_cyc[g] = 0;
                done_cnt[g]  = 0;
            end else begin
                if (start_s[g] && !busy_s[g]) begin
                    acc_cnt[g]   = 0;
                    win_cnt[g]   = 0;
                    flush_cyc[g] = 0;
                    done_cnt[g]  = 0;
                end
                // Drain phase: busy, not accepting, not yet done.
                if (busy_s[g] && !rdy_s[g] && !done_s[g]) begin
                    chk("flush shift_ce", ce_s[g], 1);
                    flush_cyc[g]++;
                end else begin
                    chk("shift_ce vs accept", ce_s[g], vld_s[g] & rdy_s[g]);
                end
                if (ov_s[g]) begin
                    if (exp_q[g].size() == 0) begin
                        chk("unexpected window", 1, 0);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk("out_x", ox_s[g], e.x);
                        chk("out_y", oy_s[g], e.y);
                        chk("border", bd_s[g], e.b);
                        chk("done with window", done_s[g], e.last);
                        exp_acc = (win_cnt[g] + W + 2 > N) ? N : win_cnt[g] + W + 2;
                        chk("window latency", acc_cnt[g], exp_acc);
                    end
                    win_cnt[g]++;
                end else begin
                    chk("border idle", bd_s[g], 0);
                    chk("done idle", done_s[g], 0);
                end
                if (done_s[g]) begin
                    done_cnt[g]++;
                end
                if (vld_s[g] && rdy_s[g]) begin
                    acc_cnt[g]++;
                end
            end
        end
    end

    task automatic push_frame(input int g);
        int w;
        int n;
        w = (g == 0) ? 4 : 2;
        n = (g == 0) ? 12 : 4;
        for (int i = 0; i < n; i++) begin
            win_t t;
            t.x    = 8'(i % w);
            t.y    = 8'(i / w);
            if (g == 0) t.b = b43[i];
            else        t.b = b22[i];
            t.last = (i == n - 1);
            exp_q[g].push_back(t);
        end
    endtask

    task automatic pulse_start(input int g);
        @(posedge clk); #1;
        start_s[g] = 1'b1;
        @(posedge clk); #1;
        start_s[g] = 1'b0;
        chk("in_ready after start", rdy_s[g], 1);
    endtask

    task automatic drive(input int g, input int duty, input int max_acc,
                         input int stray_at, output int acc);
        int cyc;
        cyc = 0;
        acc = 0;
        while (acc < max_acc && cyc < 400) begin
            vld_s[g]   = ($urandom_range(99) < duty);
            start_s[g] = (acc == stray_at);
            @(negedge clk);
            if (vld_s[g] && rdy_s[g]) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        vld_s[g]   = 1'b0;
        start_s[g] = 1'b0;
        chk("accepted pixels", acc, max_acc);
    endtask

    task automatic wait_done(input int g);
        int cyc;
        cyc = 0;
        while (!done_s[g] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("done seen", done_s[g], 1);
        #1;
    endtask

    task automatic frame_checks(input int g);
        int w;
        w = (g == 0) ? 4 : 2;
        chk("window count", win_cnt[g], w * ((g == 0) ? 3 : 2));
        chk("flush cycles", flush_cyc[g], w + 1);
        chk("done pulses", done_cnt[g], 1);
        chk("queue left", exp_q[g].size(), 0);
    endtask

    task automatic check_reset_outputs(input int g);
        chk("rst in_ready", rdy_s[g], 0);
        chk("rst shift_ce", ce_s[g], 0);
        chk("rst out_valid", ov_s[g], 0);
        chk("rst out_x", ox_s[g], 0);
        chk("rst out_y", oy_s[g], 0);
        chk("rst border", bd_s[g], 0);
        chk("rst busy", busy_s[g], 0);
        chk("rst done", done_s[g], 0);
    endtask

    initial begin
        int acc;
        start_s = '0;
        vld_s   = '0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) check_reset_outputs(g);
        rst = 1'b0;

        // 4x3, in_valid held high
        push_frame(0); pulse_start(0); drive(0, 100, 12, -1, acc);
        wait_done(0); frame_checks(0);

        // 4x3, ~50% in_valid duty
        push_frame(0); pulse_start(0); drive(0, 50, 12, -1, acc);
        wait_done(0); frame_checks(0);

        // reset after 7 accepted pixels, then a clean frame
        push_frame(0); pulse_start(0); drive(0, 100, 7, -1, acc);
        rst = 1'b1;
        exp_q[0].delete();
        @(posedge clk); #1;
        check_reset_outputs(0);
        rst = 1'b0;
        push_frame(0); pulse_start(0); drive(0, 100, 12, -1, acc);
        wait_done(0); frame_checks(0);

        // stray start in RUN and FLUSH, then back-to-back frame
        push_frame(0); pulse_start(0); drive(0, 100, 12, 8, acc);
        @(posedge clk); #1; start_s[0] = 1'b1;
        @(posedge clk); #1; start_s[0] = 1'b0;
        wait_done(0); frame_checks(0);
        push_frame(0); pulse_start(0); drive(0, 70, 12, -1, acc);
        wait_done(0); frame_checks(0);

        // 2x2 corner case, steady and with gaps
        push_frame(1); pulse_start(1); drive(1, 100, 4, -1, acc);
        wait_done(1); frame_checks(1);
        push_frame(1); pulse_start(1); drive(1, 50, 4, -1, acc);
        wait_done(1); frame_checks(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
